// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder at the far end of the MEM-stage
// request interface. Accepts one load/store at a time, holds it for LATENCY
// cycles, then commits it to an internal 2^ADDR_W x 32-bit word array.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_en        request valid, held high by the requester for the access
//   req_we        byte write strobes (0 = load, nonzero = store)
//   req_addr      byte address; word index = req_addr[ADDR_W+1:2]
//   req_wdata     store data (already lane-replicated)
//   req_release   requester consumed the response and is advancing
//   data_ready    one-cycle pulse: store committed
//   data_valid    one-cycle pulse: load data valid on read_data
//   read_data     load result, held until the next load responds
//   busy          high whenever the responder is not idle
module dmem_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_release,
    output logic        data_ready,
    output logic        data_valid,
    output logic [31:0] read_data,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BE_W-1:0]     we_q, we_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                data_ready_q, data_ready_d;
    logic                data_valid_q, data_valid_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   req_idx;
    logic [ADDR_W-1:0]   resp_idx;
    logic [BE_W-1:0]     resp_we;
    logic                unused_addr_bits;

    assign req_idx          = req_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // With LATENCY=1 RESP is entered straight from IDLE, before the request
    // registers are loaded, so the response uses the live request then.
    assign resp_idx = (state_q == S_IDLE) ? req_idx : idx_q;
    assign resp_we  = (state_q == S_IDLE) ? req_we  : we_q;

    // Next-state, request latching and registered response outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        read_data_d  = read_data_q;
        data_ready_d = 1'b0;
        data_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    we_d    = req_we;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Dropping req_en while waiting flushes the access.
                if (!req_en) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (req_release || !req_en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pulses are registered so they coincide exactly with the RESP cycle.
        if (state_d == S_RESP) begin
            if (resp_we != '0) begin
                data_ready_d = 1'b1;
            end else begin
                data_valid_d = 1'b1;
                read_data_d  = mem[resp_idx];
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            data_ready_q <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            data_ready_q <= data_ready_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            read_data_q  <= read_data_d;
        end
    end

    // Store commit at the edge ending RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_RESP) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (we_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign data_ready = data_ready_q;
    assign data_valid = data_valid_q;
    assign read_data  = read_data_q;
    assign busy       = busy_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder: the far end of the MEM-stage data request interface.
- Accepts one load or store request at a time from the pipeline, holds it for a configurable latency, then commits it.
- Commit means a byte-masked write to an internal word array, or a read returned on read_data.
- Completion is signalled with a one-cycle data_ready pulse (store) or data_valid pulse (load). The requester then releases the request before a new one is accepted.

Parameters:
- ADDR_W, 12, log2 of word count; array holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to response pulse; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_en  in  1  request valid; held high by the requester for the whole access
- req_we  in  4  byte write strobes; 4'b0000 means load, nonzero means store
- req_addr  in  32  byte address; word index = req_addr[ADDR_W+1:2], other bits ignored
- req_wdata  in  32  store data, already lane-replicated by the requester
- req_release  in  1  requester has consumed the response and is advancing (readygo & WB_allowin)
- data_ready  out  1  one-cycle pulse: store committed
- data_valid  out  1  one-cycle pulse: load data valid on read_data
- read_data  out  32  load result; held stable until the next load responds
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, counter=0, data_ready=0, data_valid=0, read_data=0. Array contents are NOT cleared. Reset mid-access aborts it: no write, no pulse.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - If req_en=1 at an edge, latch we/addr/wdata into internal registers and set counter=LATENCY-1.
  - Next state is RESP if LATENCY=1, else WAIT.
  - Inputs are sampled only on acceptance; later changes are ignored until HOLD exits.
- WAIT:
  - Decrement counter each cycle.
  - Move to RESP when the counter reaches 1 at the edge (response exactly LATENCY cycles after the acceptance edge).
  - req_en=0 in WAIT is a flush: return to IDLE with no write and no pulse.
- RESP (exactly one cycle):
  - Store: data_ready=1. At the edge ending RESP, write each byte lane i where latched we[i]=1 with wdata[8i+7:8i]; other lanes unchanged.
  - Load: data_valid=1. read_data shows the array word at the latched index during RESP and holds it afterwards.
  - A store never changes read_data.
  - Then go to HOLD unconditionally.
- HOLD: no pulses. Exit to IDLE when req_release=1 or req_en=0. The same request is never served twice.
- Back-to-back requests:
  - After leaving HOLD, IDLE accepts on the next cycle.
  - Minimum spacing between responses is LATENCY+2 cycles.
- Outputs: data_ready and data_valid are registered, mutually exclusive, and never high outside RESP.
- req_release outside HOLD is ignored.
- Address handling:
  - Bits above ADDR_W+1 are ignored, so accesses alias modulo the array size.
  - req_addr[1:0] is ignored; lane selection is fully described by req_we for stores.
  - For loads the requester extracts bytes or halfwords itself.
- Read-after-write: a load accepted after a store's RESP sees the stored bytes.

Test Plan:
- Store word then load, LATENCY=2:
  - Store req_we=4'b1111, addr=0x100, wdata=0xDEADBEEF, accepted at edge t -> data_ready high during cycle t+2 only.
  - Release in HOLD, then load addr=0x100 -> data_valid pulse two cycles after acceptance; read_data=0xDEADBEEF, still held 10 cycles later.
- Byte and halfword masks:
  - Preload 0x11223344 at 0x200.
  - Store we=4'b0100, wdata=0xAAAAAAAA -> load returns 0x11AA3344.
  - Then store we=4'b0011, wdata=0x55665566 -> load returns 0x11AA5566.
- Hold without release: keep req_en=1 with no req_release for 20 cycles after the response -> exactly one pulse; busy stays 1; a store in this state writes only once.
- Flush and reset mid-access:
  - Store to 0x300 with req_en dropped in WAIT -> no data_ready; word at 0x300 unchanged.
  - Load with rst asserted in WAIT -> all outputs 0 next cycle; state IDLE.
- LATENCY=1 and aliasing: store 0x12345678 to addr 0x4 + (1<<(ADDR_W+2)) -> data_ready one cycle after acceptance; load addr 0x4 returns 0x12345678.
